// File: rtl/qpsk_frame_sync_pkg.sv
// Shared types and helpers for the QPSK frame synchroniser: FSM states,
// symbol de-rotation and frame geometry constants.
package qpsk_frame_sync_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    localparam int UW_SYMS       = 8;
    localparam int SYMS_PER_BYTE = 4;
    localparam int UW_CNT_W      = $clog2(UW_SYMS);

    // sym = {i, q}; k selects which of the four carrier-phase rotations to undo.
    function automatic logic [1:0] derotate(input logic [1:0] sym, input logic [1:0] k);
        logic [1:0] r;
        case (k)
            2'd0:    r = sym;
            2'd1:    r = {sym[0], ~sym[1]};
            2'd2:    r = ~sym;
            default: r = {~sym[0], sym[1]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/qpsk_frame_sync_uw_correlator.sv
// Hamming distance between the 8-symbol window and the unique word under
// each of the four de-rotations.
module qpsk_frame_sync_uw_correlator
    import qpsk_frame_sync_pkg::*;
#(
    parameter logic [15:0] UW = 16'hEB90
) (
    input  logic [15:0]     i_sr,
    output logic [3:0][4:0] o_dist
);

    logic [1:0] w_sym;

    always_comb begin
        w_sym  = 2'b00;
        o_dist = '0;
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < UW_SYMS; s++) begin
                w_sym     = derotate(i_sr[2*s +: 2], 2'(k)) ^ UW[2*s +: 2];
                o_dist[k] = o_dist[k] + 5'(w_sym[1]) + 5'(w_sym[0]);
            end
        end
    end

endmodule

// File: rtl/qpsk_frame_sync.sv
// Unique-word hunt under all carrier rotations, payload de-rotation and byte
// packing, with flywheeling across missed unique words.
module qpsk_frame_sync
    import qpsk_frame_sync_pkg::*;
#(
    parameter logic [15:0] UW          = 16'hEB90,
    parameter int          UW_TOL      = 1,
    parameter int          FRAME_BYTES = 32,
    parameter int          MISS_MAX    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync_out_I,
    input  logic       sync_out_Q,
    input  logic       sync_flag,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_start,
    output logic       locked,
    output logic [1:0] phase_rot,
    output logic [1:0] o_dbg_state,
    output logic [2:0] o_dbg_miss_cnt
);

    state_t                r_state;
    logic                  r_eval;
    logic [15:0]           r_sr;
    logic [7:0]            r_byte;
    logic [1:0]            r_sym_cnt;
    logic [7:0]            r_byte_cnt;
    logic [UW_CNT_W-1:0]   r_uw_cnt;
    logic [2:0]            r_miss_cnt;

    logic [3:0][4:0]       w_dist;
    logic                  w_any_hit;
    logic [1:0]            w_hit_k;
    logic                  w_check_hit;
    logic                  w_miss_final;

    qpsk_frame_sync_uw_correlator #(.UW(UW)) u_corr (
        .i_sr   (r_sr),
        .o_dist (w_dist)
    );

    // Descending scan so the lowest matching rotation wins a tie.
    always_comb begin
        w_hit_k   = 2'd0;
        w_any_hit = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (w_dist[k] <= 5'(UW_TOL)) begin
                w_hit_k   = 2'(k);
                w_any_hit = 1'b1;
            end
        end
    end

    assign w_check_hit    = (w_dist[phase_rot] <= 5'(UW_TOL));
    assign w_miss_final   = (({1'b0, r_miss_cnt} + 4'd1) >= 4'(MISS_MAX));
    assign o_dbg_state    = r_state;
    assign o_dbg_miss_cnt = r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_SEARCH;
            r_eval      <= 1'b0;
            r_sr        <= '0;
            r_byte      <= '0;
            r_sym_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_uw_cnt    <= '0;
            r_miss_cnt  <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            phase_rot   <= '0;
        end else begin
            r_eval      <= sync_flag;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;

            // Raw symbols always enter the window; only payload is de-rotated.
            if (sync_flag) begin
                r_sr <= {r_sr[13:0], sync_out_I, sync_out_Q};
                if (r_state == ST_PAYLOAD) begin
                    r_byte    <= {r_byte[5:0], derotate({sync_out_I, sync_out_Q}, phase_rot)};
                    r_sym_cnt <= (r_sym_cnt == 2'(SYMS_PER_BYTE-1)) ? 2'd0 : r_sym_cnt + 2'd1;
                end
                if (r_state == ST_CHECK) begin
                    r_uw_cnt <= r_uw_cnt + 1'b1;
                end
            end

            if (r_eval) begin
                case (r_state)
                    ST_SEARCH: begin
                        if (w_any_hit) begin
                            phase_rot   <= w_hit_k;
                            locked      <= 1'b1;
                            frame_start <= 1'b1;
                            r_byte_cnt  <= '0;
                            r_sym_cnt   <= '0;
                            r_state     <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        // A wrapped symbol counter on eval means a byte just completed.
                        if (r_sym_cnt == 2'd0) begin
                            data_out   <= r_byte;
                            data_valid <= 1'b1;
                            if (r_byte_cnt == 8'(FRAME_BYTES-1)) begin
                                r_byte_cnt <= '0;
                                r_uw_cnt   <= '0;
                                r_state    <= ST_CHECK;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 8'd1;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (r_uw_cnt == '0) begin
                            r_byte_cnt <= '0;
                            r_sym_cnt  <= '0;
                            if (w_check_hit) begin
                                r_miss_cnt  <= '0;
                                frame_start <= 1'b1;
                                r_state     <= ST_PAYLOAD;
                            end else if (!w_miss_final) begin
                                r_miss_cnt <= r_miss_cnt + 3'd1;
                                r_state    <= ST_PAYLOAD;
                            end else begin
                                r_miss_cnt <= '0;
                                locked     <= 1'b0;
                                r_state    <= ST_SEARCH;
                            end
                        end
                    end
                    default: r_state <= ST_SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// Directed bench for qpsk_frame_sync: stimulus pushes expected bytes and
// frame_start phases into queues; a negedge monitor pops and compares.
module tb_qpsk_frame_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sync_out_I = 1'b0;
    logic       sync_out_Q = 1'b0;
    logic       sync_flag = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_start;
    logic       locked;
    logic [1:0] phase_rot;
    logic [1:0] dbg_state;
    logic [2:0] dbg_miss_cnt;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_flag_cyc = 0;
    int tx_mode = 0;
    int locked_hi = 0;

    logic [7:0]  exp_q[$];
    logic [1:0]  exp_fs_q[$];
    logic [15:0] uw = 16'hEB90;
    logic [15:0] uw_pat[4];
    logic [15:0] win;
    logic [1:0]  cand;

    qpsk_frame_sync dut (
        .clk            (clk),
        .rst            (rst),
        .sync_out_I     (sync_out_I),
        .sync_out_Q     (sync_out_Q),
        .sync_flag      (sync_flag),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .frame_start    (frame_start),
        .locked         (locked),
        .phase_rot      (phase_rot),
        .o_dbg_state    (dbg_state),
        .o_dbg_miss_cnt (dbg_miss_cnt)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter-side channel rotation; mode m is undone by receiver rotation k=m.
    function automatic logic [1:0] tx_map(input logic [1:0] s, input int mode);
        case (mode)
            1:       return {~s[0], s[1]};
            2:       return ~s;
            3:       return {s[0], ~s[1]};
            default: return s;
        endcase
    endfunction

    function automatic logic near_uw(input logic [15:0] w);
        for (int m = 0; m < 4; m++) begin
            if ($countones(w ^ uw_pat[m]) <= 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Driver tasks: one symbol every 4 clocks, strobe high for 1 clock.
    task automatic send_sym(input logic [1:0] s);
        logic [1:0] t;
        t = tx_map(s, tx_mode);
        @(negedge clk);
        sync_out_I    = t[1];
        sync_out_Q    = t[0];
        sync_flag     = 1'b1;
        last_flag_cyc = cyc;
        @(negedge clk);
        sync_flag = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int s = 7; s >= 0; s--) send_sym(w[2*s +: 2]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int s = 3; s >= 0; s--) send_sym(b[2*s +: 2]);
    endtask

    task automatic send_frame_bytes(input int first, input int count, input logic expect_out);
        logic [7:0] b;
        for (int n = 0; n < count; n++) begin
            b = 8'(first + n);
            if (expect_out) exp_q.push_back(b);
            send_byte(b);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        sync_flag = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_drained(input string name);
        check({name, "_bytes_left"}, exp_q.size(), 0);
        check({name, "_fs_left"}, exp_fs_q.size(), 0);
        exp_q.delete();
        exp_fs_q.delete();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (locked) locked_hi++;
            if (data_valid) begin
                check("dv_latency", cyc - last_flag_cyc, 2);
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_data_valid: data_valid=1 data_out=0x%0h, expected no byte", data_out);
                end else begin
                    check("data_out", data_out, exp_q.pop_front());
                end
            end
            if (frame_start) begin
                check("fs_latency", cyc - last_flag_cyc, 2);
                check("fs_locked", locked, 1);
                n_tests++;
                if (exp_fs_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame_start: frame_start=1 phase_rot=%0d, expected none", phase_rot);
                end else begin
                    check("fs_phase_rot", phase_rot, exp_fs_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int m = 0; m < 4; m++) begin
            for (int s = 0; s < 8; s++) uw_pat[m][2*s +: 2] = tx_map(uw[2*s +: 2], m);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_locked", locked, 0);
        check("rst_phase_rot", phase_rot, 0);
        check("rst_state", dbg_state, 0);
        check("rst_miss_cnt", dbg_miss_cnt, 0);
        rst = 1'b0;

        // 1: unrotated UW, 32 bytes, UW
        tx_mode = 0;
        exp_fs_q.push_back(2'd0);
        send_word(uw);
        send_frame_bytes(0, 32, 1'b1);
        exp_fs_q.push_back(2'd0);
        send_word(uw);
        check("t1_locked", locked, 1);
        check("t1_phase_rot", phase_rot, 0);
        check("t1_miss_cnt", dbg_miss_cnt, 0);
        check("t1_state", dbg_state, 1);
        check_drained("t1");

        // 2: same stream rotated by 180 degrees
        do_reset();
        tx_mode = 2;
        exp_fs_q.push_back(2'd2);
        send_word(uw);
        send_frame_bytes(0, 32, 1'b1);
        exp_fs_q.push_back(2'd2);
        send_word(uw);
        check("t2_phase_rot", phase_rot, 2);
        check_drained("t2");

        // 2b: 90-degree rotation recovered with k=1
        do_reset();
        tx_mode = 1;
        exp_fs_q.push_back(2'd1);
        send_word(uw);
        exp_q.push_back(8'hA5); send_byte(8'hA5);
        exp_q.push_back(8'h3C); send_byte(8'h3C);
        check("t2b_phase_rot", phase_rot, 1);
        check_drained("t2b");

        // 3: tolerance boundary
        do_reset();
        tx_mode = 0;
        exp_fs_q.push_back(2'd0);
        send_word(uw ^ 16'h0100);
        exp_q.push_back(8'h5A); send_byte(8'h5A);
        check("t3_1bit_locked", locked, 1);
        check_drained("t3a");
        do_reset();
        send_word(uw ^ 16'h0101);
        repeat (2) @(negedge clk);
        check("t3_2bit_locked", locked, 0);
        check("t3_2bit_state", dbg_state, 0);
        check_drained("t3b");

        // 4: three missed UWs at phase 2 then relock
        do_reset();
        tx_mode = 2;
        exp_fs_q.push_back(2'd2);
        send_word(uw);
        send_frame_bytes(0, 32, 1'b1);
        send_word(~uw);
        check("t4_miss1_cnt", dbg_miss_cnt, 1);
        check("t4_miss1_locked", locked, 1);
        send_frame_bytes(32, 32, 1'b1);
        send_word(uw ^ 16'h0003);
        check("t4_miss2_cnt", dbg_miss_cnt, 2);
        send_frame_bytes(64, 32, 1'b1);
        check("t4_pre_drop_locked", locked, 1);
        send_word(uw ^ 16'h0003);
        check("t4_drop_locked", locked, 0);
        check("t4_drop_state", dbg_state, 0);
        check("t4_drop_miss_cnt", dbg_miss_cnt, 0);
        check("t4_drop_phase_kept", phase_rot, 2);
        exp_fs_q.push_back(2'd2);
        send_word(uw);
        exp_q.push_back(8'hC3); send_byte(8'hC3);
        check("t4_relock", locked, 1);
        check_drained("t4");

        // 5: async reset in the middle of byte 10
        do_reset();
        tx_mode = 0;
        exp_fs_q.push_back(2'd0);
        send_word(uw);
        send_frame_bytes(0, 10, 1'b1);
        send_sym(2'b10);
        send_sym(2'b01);
        rst = 1'b1;
        #1;
        check("t5_rst_locked", locked, 0);
        check("t5_rst_phase", phase_rot, 0);
        check("t5_rst_data_out", data_out, 0);
        check("t5_rst_state", dbg_state, 0);
        @(negedge clk);
        rst = 1'b0;
        send_sym(2'b11);
        send_sym(2'b00);
        send_frame_bytes(11, 5, 1'b0);
        check("t5_after_rst_locked", locked, 0);
        exp_fs_q.push_back(2'd0);
        send_word(uw);
        exp_q.push_back(8'h96); send_byte(8'h96);
        check_drained("t5");

        // 6: random symbols with every near-UW window steered away
        do_reset();
        tx_mode = 0;
        win = '0;
        locked_hi = 0;
        for (int n = 0; n < 10000; n++) begin
            cand = 2'($urandom_range(0, 3));
            for (int t = 0; t < 4; t++) begin
                if (!near_uw({win[13:0], cand})) break;
                cand = cand + 2'd1;
            end
            win = {win[13:0], cand};
            send_sym(cand);
        end
        check("t6_locked_cycles", locked_hi, 0);
        check("t6_state", dbg_state, 0);
        check_drained("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
